// File: rtl/cpu_pkg.sv
// Shared cpu definitions: loader state encoding and default memory geometry.
// The loader checksum trailer is enabled by defining LOADER_CHKSUM_EN.
package cpu_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: host byte stream (valid/ready) plus the memory write port.
// The loader uses the slave side; the byte source and memory use master.
interface prog_loader_if import cpu_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/byte_to_word_packer.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in the MSBs.
// word_valid flags the byte that completes a word, in the cycle it is accepted.
module byte_to_word_packer import cpu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    localparam int BPW = DATA_W / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPW - 1);

    logic [CW-1:0] cnt;

    assign word_valid = byte_en && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (byte_en) begin
            cnt  <= word_valid ? '0 : cnt + 1'b1;
            word <= (word << 8) | DATA_W'(byte_in);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: framed byte stream -> consecutive memory words from address 0.
// Holds the cpu in reset until loaded; LOADER_CHKSUM_EN adds a sum trailer byte.
module prog_loader import cpu_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    localparam int CAP = 1 << ADDR_W;

`ifdef LOADER_CHKSUM_EN
    localparam ld_state_t S_END = S_CHK;
`else
    localparam ld_state_t S_END = S_DONE;
`endif

    ld_state_t         state, state_nxt;
    logic [ADDR_W-1:0] word_idx, last_idx;
    logic [DATA_W-1:0] word;
    logic              word_valid, xfer, rearm, last_word, hdr_bad;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign rearm     = start && (state == S_DONE || state == S_ERR);
    assign last_word = (word_idx == last_idx);
    assign hdr_bad   = (bus.in_data == 8'd0) ||
                       ({1'b0, bus.in_data} > 9'(CAP));

    assign bus.in_ready  = (state == S_HDR) || (state == S_DATA) ||
                           (state == S_CHK);
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.mem_addr  = word_idx;
    assign bus.mem_wdata = word;
    assign done          = (state == S_DONE);
    assign error         = (state == S_ERR);
    assign cpu_hold      = (state != S_DONE);

    byte_to_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (rearm),
        .byte_en    (xfer && state == S_DATA),
        .byte_in    (bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef LOADER_CHKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (rearm) begin
            sum <= '0;
        end else if (xfer && state == S_DATA) begin
            sum <= sum + bus.in_data;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_HDR:   if (xfer) state_nxt = hdr_bad ? S_ERR : S_DATA;
            S_DATA:  if (word_valid) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_word ? S_END : S_DATA;
`ifdef LOADER_CHKSUM_EN
            S_CHK:   if (xfer) state_nxt = (bus.in_data == sum) ? S_DONE : S_ERR;
`endif
            S_DONE,
            S_ERR:   if (start) state_nxt = S_HDR;
            default: state_nxt = S_ERR;
        endcase
    end

    // last_idx = N-1 always fits: a valid N never exceeds the capacity
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_HDR;
            word_idx <= '0;
            last_idx <= '0;
        end else begin
            state <= state_nxt;
            if (rearm) begin
                word_idx <= '0;
            end else if (state == S_WRITE && !last_word) begin
                word_idx <= word_idx + 1'b1;
            end
            if (state == S_HDR && xfer) begin
                last_idx <= ADDR_W'(bus.in_data - 8'd1);
            end
        end
    end

endmodule
